// File: rtl/pwm_pkg.sv
// pwm_pkg: widths, constants and the duty compare shared by the PWM peripheral.
package pwm_pkg;
   localparam int PWM_CNT_W  = 8;
   localparam int PWM_NUM_CH = 16;

   typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

   localparam pwm_cnt_t PWM_DUTY_FULL = 8'hFF;

   // Full-scale duty is held high for the whole period instead of dropping on the last count.
   function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
      return (duty == PWM_DUTY_FULL) || (cnt < duty);
   endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides m_clk down to one PWM tick every CLK_DIV cycles.
module pwm_prescaler #(
   parameter int CLK_DIV = 4
) (
   input  logic m_clk,
   input  logic rst,
   output logic tick
);
   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] div_q, div_d;

   always_comb begin
      tick  = div_q == LAST;
      div_d = tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge m_clk) div_q <= rst ? '0 : div_d;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 output pins, each forced low, static high or driven by a shared 8-bit PWM.
// Define PWM_DUTY_SHADOW_EN to defer duty updates to the next period boundary.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  m_clk,
   input  logic                  rst,
   input  logic [7:0]            en_reg_out_7_0,
   input  logic [7:0]            en_reg_out_15_8,
   input  logic [7:0]            en_reg_pwm_7_0,
   input  logic [7:0]            en_reg_pwm_15_8,
   input  logic [7:0]            pwm_duty_cycle,
   output logic [PWM_NUM_CH-1:0] out,
   output logic                  period_start
);
   logic                  tick, wrap, lvl, ps_d, ps_q;
   pwm_cnt_t              cnt_q, cnt_d, duty_active;
   logic [PWM_NUM_CH-1:0] en_out, en_pwm, out_d, out_q;

   pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .m_clk(m_clk),
      .rst  (rst),
      .tick (tick)
   );

`ifdef PWM_DUTY_SHADOW_EN
   pwm_cnt_t duty_q, duty_d;

   always_comb duty_d = wrap ? pwm_duty_cycle : duty_q;

   always_ff @(posedge m_clk) duty_q <= rst ? '0 : duty_d;

   assign duty_active = duty_q;
`else
   assign duty_active = pwm_duty_cycle;
`endif

   always_comb begin
      en_out = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      wrap   = tick && (cnt_q == '1);
      cnt_d  = cnt_q + PWM_CNT_W'(tick);
      lvl    = pwm_level(cnt_q, duty_active);
      // Disabled pins stay low whatever their PWM select says.
      out_d  = en_out & (~en_pwm | {PWM_NUM_CH{lvl}});
      ps_d   = wrap;
   end

   always_ff @(posedge m_clk) begin
      if (rst) begin
         cnt_q <= '0;
         out_q <= '0;
         ps_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
         ps_q  <= ps_d;
      end
   end

   assign out          = out_q;
   assign period_start = ps_q;
endmodule
